// File: rtl/rv32i_mc_ctrl_v2.sv
// Multi-cycle RV32I control FSM: Moore decode of state plus memory handshake,
// with memory timeout, eof halt and illegal-opcode trap.
module rv32i_mc_ctrl_v2 #(
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter bit          EN_UJ        = 1'b1,
  parameter bit          TRAP_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       eof,
  input  logic       zero,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       mem_read,
  output logic       mem_write,
  output logic       IRwrite,
  output logic       reg_write,
  output logic       PCwrite,
  output logic       PCwriteCond,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALU_op,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       halted,
  output logic       trap,
  output logic       bus_err
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIM =
    (MEM_TIMEOUT == 0) ? '0 : CW'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXE_R  = 4'd7,
    S_EXE_I  = 4'd8,
    S_ALUWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_JAL    = 4'd11,
    S_JALR   = 4'd12,
    S_UPPER  = 4'd13,
    S_HALT   = 4'd14,
    S_TRAP   = 4'd15
  } state_e;

  state_e        st_q, st_d;
  logic          eof_q;
  logic          berr_q, berr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic   eof_any, is_mem, tmo;
  logic   op_mem, op_r, op_i, op_br;
  logic   op_jal, op_jalr, op_up;
  state_e nxt_fetch, ill_tgt;
  logic   unused_f3;

  assign unused_f3 = ^funct3[2:1];

  assign eof_any   = eof_q | eof;
  assign nxt_fetch = eof_any ? S_HALT : S_FETCH;
  assign ill_tgt   = TRAP_ILLEGAL ? S_TRAP : nxt_fetch;

  assign is_mem = (st_q == S_FETCH) || (st_q == S_MEMRD) ||
                  (st_q == S_MEMWR);
  // ready in the limit cycle still completes the access
  assign tmo = (MEM_TIMEOUT != 0) && !mem_ready && (cnt_q == LIM);

  assign op_mem  = (opcode == OP_LD) || (opcode == OP_ST);
  assign op_r    = (opcode == OP_R);
  assign op_i    = (opcode == OP_I);
  assign op_br   = (opcode == OP_BR);
  assign op_jal  = EN_UJ && (opcode == OP_JAL);
  assign op_jalr = EN_UJ && (opcode == OP_JALR);
  assign op_up   = EN_UJ &&
                   ((opcode == OP_LUI) || (opcode == OP_AUI));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= S_IDLE;
      eof_q  <= 1'b0;
      berr_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      eof_q  <= eof_q | eof;
      berr_q <= berr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    st_d        = st_q;
    berr_d      = berr_q;
    cnt_d       = '0;
    IorD        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    IRwrite     = 1'b0;
    reg_write   = 1'b0;
    PCwrite     = 1'b0;
    PCwriteCond = 1'b0;
    MemtoReg    = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALU_op      = 2'b00;
    PCSource    = 2'b00;
    halted      = 1'b0;
    trap        = 1'b0;
    bus_err     = 1'b0;
    if (is_mem && !mem_ready) cnt_d = cnt_q + CW'(1);
    case (st_q)
      S_IDLE: st_d = eof_any ? S_HALT : S_FETCH;
      S_FETCH: begin
        mem_read = 1'b1;
        ALUSrcB  = 2'b01;
        if (mem_ready) begin
          IRwrite = 1'b1;
          PCwrite = 1'b1;
          st_d    = S_DECODE;
        end else if (tmo) begin
          st_d   = S_TRAP;
          berr_d = 1'b1;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b10;
        unique case (1'b1)
          op_mem:  st_d = S_MEMADR;
          op_r:    st_d = S_EXE_R;
          op_i:    st_d = S_EXE_I;
          op_br:   st_d = S_BRANCH;
          op_jal:  st_d = S_JAL;
          op_jalr: st_d = S_JALR;
          op_up:   st_d = S_UPPER;
          default: st_d = ill_tgt;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        st_d    = opcode[5] ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) st_d = S_MEMWB;
        else if (tmo) begin
          st_d   = S_TRAP;
          berr_d = 1'b1;
        end
      end
      S_MEMWR: begin
        IorD      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) st_d = nxt_fetch;
        else if (tmo) begin
          st_d   = S_TRAP;
          berr_d = 1'b1;
        end
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        MemtoReg  = 2'b01;
        st_d      = nxt_fetch;
      end
      S_EXE_R: begin
        ALUSrcA = 2'b01;
        ALU_op  = 2'b01;
        st_d    = S_ALUWB;
      end
      S_EXE_I: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ALU_op  = 2'b10;
        st_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        st_d      = nxt_fetch;
      end
      S_BRANCH: begin
        ALUSrcA     = 2'b01;
        ALU_op      = 2'b11;
        PCSource    = 2'b01;
        PCwriteCond = zero ^ funct3[0];
        st_d        = nxt_fetch;
      end
      S_JAL: begin
        reg_write = 1'b1;
        MemtoReg  = 2'b10;
        PCwrite   = 1'b1;
        PCSource  = 2'b01;
        st_d      = nxt_fetch;
      end
      S_JALR: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        PCSource  = 2'b10;
        PCwrite   = 1'b1;
        reg_write = 1'b1;
        MemtoReg  = 2'b10;
        st_d      = nxt_fetch;
      end
      S_UPPER: begin
        ALUSrcA = opcode[5] ? 2'b10 : 2'b11;
        ALUSrcB = 2'b10;
        st_d    = S_ALUWB;
      end
      S_HALT: halted = 1'b1;
      S_TRAP: begin
        trap    = !berr_q;
        bus_err = berr_q;
      end
    endcase
  end

  assign state = st_q;

endmodule

// File: tb/tb_rv32i_mc_ctrl_v2.sv
// Directed bench for rv32i_mc_ctrl_v2: stimulus queues expected per-cycle
// state/control words, a negedge monitor pops and compares them.
module tb_rv32i_mc_ctrl_v2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       eof = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;

  always #5 clk = ~clk;

  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] BAD  = 7'b1111111;

  wire [6:0] en1, en2;
  wire [1:0] mr1, sa1, sb1, op1, ps1;
  wire [1:0] mr2, sa2, sb2, op2, ps2;
  wire [3:0] st1, st2;
  wire       h1, t1, b1, h2, t2, b2;
  wire [19:0] ctl1, ctl2;

  assign ctl1 = {en1, mr1, sa1, sb1, op1, ps1, h1, t1, b1};
  assign ctl2 = {en2, mr2, sa2, sb2, op2, ps2, h2, t2, b2};

  rv32i_mc_ctrl_v2 #(
    .MEM_TIMEOUT(4), .EN_UJ(1'b1), .TRAP_ILLEGAL(1'b1)
  ) u1 (
    .clk(clk), .rst(rst), .eof(eof), .zero(zero),
    .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
    .IorD(en1[6]), .mem_read(en1[5]), .mem_write(en1[4]),
    .IRwrite(en1[3]), .reg_write(en1[2]), .PCwrite(en1[1]),
    .PCwriteCond(en1[0]), .MemtoReg(mr1), .ALUSrcA(sa1),
    .ALUSrcB(sb1), .ALU_op(op1), .PCSource(ps1), .state(st1),
    .halted(h1), .trap(t1), .bus_err(b1)
  );

  rv32i_mc_ctrl_v2 #(
    .MEM_TIMEOUT(4), .EN_UJ(1'b0), .TRAP_ILLEGAL(1'b1)
  ) u2 (
    .clk(clk), .rst(rst), .eof(eof), .zero(zero),
    .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
    .IorD(en2[6]), .mem_read(en2[5]), .mem_write(en2[4]),
    .IRwrite(en2[3]), .reg_write(en2[2]), .PCwrite(en2[1]),
    .PCwriteCond(en2[0]), .MemtoReg(mr2), .ALUSrcA(sa2),
    .ALUSrcB(sb2), .ALU_op(op2), .PCSource(ps2), .state(st2),
    .halted(h2), .trap(t2), .bus_err(b2)
  );

  typedef struct {
    logic        chk;
    logic [3:0]  st;
    logic [19:0] ctl;
    string       nm;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   errors = 0;
  int   checks = 0;

  // en = {IorD,mem_read,mem_write,IRwrite,reg_write,PCwrite,PCwriteCond}
  function automatic logic [19:0] cv(
    input logic [6:0] en, input logic [1:0] m2r, input logic [1:0] sa,
    input logic [1:0] sb, input logic [1:0] op, input logic [1:0] ps,
    input logic [2:0] hte);
    return {en, m2r, sa, sb, op, ps, hte};
  endfunction

  function automatic exp_t mk(input logic [3:0] s, input logic [19:0] c,
                              input string n);
    exp_t r;
    r.chk = 1'b1;
    r.st  = s;
    r.ctl = c;
    r.nm  = n;
    return r;
  endfunction

  task automatic check(input string who, input exp_t x,
                       input logic [3:0] s, input logic [19:0] c);
    if (x.chk) begin
      checks++;
      if (s !== x.st || c !== x.ctl) begin
        errors++;
        $display("FAIL %s %s @%0t: got state=%0d ctl=%b, want state=%0d ctl=%b",
                 who, x.nm, $time, s, c, x.st, x.ctl);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t a;
    exp_t b;
    if (q1.size() > 0 && q2.size() > 0) begin
      a = q1.pop_front();
      b = q2.pop_front();
      check("u1", a, st1, ctl1);
      check("u2", b, st2, ctl2);
    end
  end

  exp_t E_IDLE, E_FW, E_FR, E_DEC, E_MA, E_MRD, E_MWB, E_EXR, E_WB;
  exp_t E_BR1, E_BR0, E_JAL, E_JR, E_LUI, E_HALT, E_TRP, E_BUS;

  task automatic cyc(input logic r, input logic z, input logic [6:0] op,
                     input logic [2:0] f3, input logic e,
                     input exp_t x1, input exp_t x2);
    @(posedge clk);
    #1;
    mem_ready = r;
    zero      = z;
    opcode    = op;
    funct3    = f3;
    eof       = e;
    q1.push_back(x1);
    q2.push_back(x2);
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_ready = 1'b0;
    eof       = 1'b0;
    q1.push_back(E_IDLE);
    q2.push_back(E_IDLE);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q1.push_back(E_IDLE);
    q2.push_back(E_IDLE);
  endtask

  initial begin
    E_IDLE = mk(4'd0,  cv(7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "idle");
    E_FW   = mk(4'd1,  cv(7'b0100000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000), "fetch_wait");
    E_FR   = mk(4'd1,  cv(7'b0101010, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000), "fetch_rdy");
    E_DEC  = mk(4'd2,  cv(7'b0000000, 2'b00, 2'b11, 2'b10, 2'b00, 2'b00, 3'b000), "decode");
    E_MA   = mk(4'd3,  cv(7'b0000000, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000), "memadr");
    E_MRD  = mk(4'd4,  cv(7'b1100000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "memrd");
    E_MWB  = mk(4'd5,  cv(7'b0000100, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "memwb");
    E_EXR  = mk(4'd7,  cv(7'b0000000, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 3'b000), "exe_r");
    E_WB   = mk(4'd9,  cv(7'b0000100, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "aluwb");
    E_BR1  = mk(4'd10, cv(7'b0000001, 2'b00, 2'b01, 2'b00, 2'b11, 2'b01, 3'b000), "branch_take");
    E_BR0  = mk(4'd10, cv(7'b0000000, 2'b00, 2'b01, 2'b00, 2'b11, 2'b01, 3'b000), "branch_skip");
    E_JAL  = mk(4'd11, cv(7'b0000110, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000), "jal");
    E_JR   = mk(4'd12, cv(7'b0000110, 2'b10, 2'b01, 2'b10, 2'b00, 2'b10, 3'b000), "jalr");
    E_LUI  = mk(4'd13, cv(7'b0000000, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 3'b000), "upper_lui");
    E_HALT = mk(4'd14, cv(7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100), "halt");
    E_TRP  = mk(4'd15, cv(7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010), "trap");
    E_BUS  = mk(4'd15, cv(7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001), "bus_err");

    rst_pulse();

    // ADD, memory always ready
    cyc(1, 0, ADD, 3'b000, 0, E_FR,  E_FR);
    cyc(1, 0, ADD, 3'b000, 0, E_DEC, E_DEC);
    cyc(1, 0, ADD, 3'b000, 0, E_EXR, E_EXR);
    cyc(1, 0, ADD, 3'b000, 0, E_WB,  E_WB);

    // LW, 3 wait cycles in FETCH and MEMRD: 11 cycles
    repeat (3) cyc(0, 0, LW, 3'b010, 0, E_FW, E_FW);
    cyc(1, 0, LW, 3'b010, 0, E_FR,  E_FR);
    cyc(1, 0, LW, 3'b010, 0, E_DEC, E_DEC);
    cyc(0, 0, LW, 3'b010, 0, E_MA,  E_MA);
    repeat (3) cyc(0, 0, LW, 3'b010, 0, E_MRD, E_MRD);
    cyc(1, 0, LW, 3'b010, 0, E_MRD, E_MRD);
    cyc(1, 0, LW, 3'b010, 0, E_MWB, E_MWB);

    // BEQ and BNE with zero=1
    cyc(1, 1, BR, 3'b000, 0, E_FR,  E_FR);
    cyc(1, 1, BR, 3'b000, 0, E_DEC, E_DEC);
    cyc(1, 1, BR, 3'b000, 0, E_BR1, E_BR1);
    cyc(1, 1, BR, 3'b001, 0, E_FR,  E_FR);
    cyc(1, 1, BR, 3'b001, 0, E_DEC, E_DEC);
    cyc(1, 1, BR, 3'b001, 0, E_BR0, E_BR0);

    // JALR: u2 has no UJ support and traps
    cyc(1, 0, JALR, 3'b000, 0, E_FR,  E_FR);
    cyc(1, 0, JALR, 3'b000, 0, E_DEC, E_DEC);
    cyc(1, 0, JALR, 3'b000, 0, E_JR,  E_TRP);

    cyc(1, 0, JAL, 3'b000, 0, E_FR,  E_TRP);
    cyc(1, 0, JAL, 3'b000, 0, E_DEC, E_TRP);
    cyc(1, 0, JAL, 3'b000, 0, E_JAL, E_TRP);

    cyc(1, 0, LUI, 3'b000, 0, E_FR,  E_TRP);
    cyc(1, 0, LUI, 3'b000, 0, E_DEC, E_TRP);
    cyc(1, 0, LUI, 3'b000, 0, E_LUI, E_TRP);
    cyc(1, 0, LUI, 3'b000, 0, E_WB,  E_TRP);

    // eof pulsed during EXE_R: write-back completes, then HALT
    cyc(1, 0, ADD, 3'b000, 0, E_FR,   E_TRP);
    cyc(1, 0, ADD, 3'b000, 0, E_DEC,  E_TRP);
    cyc(1, 0, ADD, 3'b000, 1, E_EXR,  E_TRP);
    cyc(1, 0, ADD, 3'b000, 0, E_WB,   E_TRP);
    cyc(1, 0, ADD, 3'b000, 0, E_HALT, E_TRP);
    cyc(1, 0, ADD, 3'b000, 0, E_HALT, E_TRP);

    rst_pulse();

    // memory never ready: 4 wait cycles then bus error
    repeat (4) cyc(0, 0, ADD, 3'b000, 0, E_FW, E_FW);
    cyc(0, 0, ADD, 3'b000, 0, E_BUS, E_BUS);
    cyc(0, 0, ADD, 3'b000, 0, E_BUS, E_BUS);

    rst_pulse();

    // illegal opcode
    cyc(1, 0, BAD, 3'b000, 0, E_FR,  E_FR);
    cyc(1, 0, BAD, 3'b000, 0, E_DEC, E_DEC);
    cyc(1, 0, BAD, 3'b000, 0, E_TRP, E_TRP);
    cyc(1, 0, BAD, 3'b000, 0, E_TRP, E_TRP);

    rst_pulse();

    repeat (3) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
